mc_controller: RTL and testbench

Multi-cycle main controller for the MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the same datapath select encodings, adds a data-memory request/acknowledge handshake, and produces a retire pulse. It sits between the instruction register (op/func) plus the ALU flags and every datapath write enable and mux select.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 37 +++
 rtl/mc_controller.sv | 176 +++++++++++++++++
 tb/tb_mc_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs, states,
// datapath select values and the instruction classes produced by mc_decode.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_SLL  = 6'b000000;

   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_SLL  = 3'b100;
   localparam logic [2:0] ALU_NONE = 3'b111;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_LUI = 2'b01;
   localparam logic [1:0] M2R_MEM = 2'b10;
   localparam logic [1:0] M2R_PC4 = 2'b11;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;
   localparam logic [1:0] PCSRC_RS  = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      CL_ILLEGAL, CL_ADDU, CL_SUBU, CL_SLL, CL_JR, CL_LW,
      CL_SW, CL_BEQ, CL_BLEZ, CL_LUI, CL_ORI, CL_JAL
   } inst_class_t;

   function automatic logic [2:0] rtype_alu(input inst_class_t c);
      case (c)
         CL_SUBU: return ALU_SUB;
         CL_SLL:  return ALU_SLL;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to instruction class plus a
// legal flag. Anything not recognised maps to CL_ILLEGAL.
module mc_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   output inst_class_t iclass,
   output logic        legal
);

   always_comb begin
      iclass = CL_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADDU: iclass = CL_ADDU;
               FN_SUBU: iclass = CL_SUBU;
               FN_JR:   iclass = CL_JR;
               FN_SLL:  iclass = CL_SLL;
               default: iclass = CL_ILLEGAL;
            endcase
         end
         OP_LW:   iclass = CL_LW;
         OP_SW:   iclass = CL_SW;
         OP_BEQ:  iclass = CL_BEQ;
         OP_BLEZ: iclass = CL_BLEZ;
         OP_LUI:  iclass = CL_LUI;
         OP_ORI:  iclass = CL_ORI;
         OP_JAL:  iclass = CL_JAL;
         default: iclass = CL_ILLEGAL;
      endcase
   end

   assign legal = (iclass != CL_ILLEGAL);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and selects.
module mc_controller
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       lez,
   input  logic       dmem_ack,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrc,
   output logic [2:0] ALUCtrl,
   output logic       ExtOp,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       retire,
   output logic       illegal,
   output logic [2:0] state
);

   state_t      state_q, state_d;
   inst_class_t iclass;
   logic        legal;

   mc_decode u_decode (
      .op     (op),
      .func   (func),
      .iclass (iclass),
      .legal  (legal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = ST_TRAP;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            if (!legal)                                    state_d = ST_TRAP;
            else if (iclass == CL_JAL || iclass == CL_JR)  state_d = ST_FETCH;
            else if (iclass == CL_LUI)                     state_d = ST_WB;
            else                                           state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (iclass)
               CL_ADDU, CL_SUBU, CL_SLL, CL_ORI: state_d = ST_WB;
               CL_LW, CL_SW:                     state_d = ST_MEM;
               CL_BEQ, CL_BLEZ:                  state_d = ST_FETCH;
               default:                          state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (!dmem_ack)            state_d = ST_MEM;
            else if (iclass == CL_SW) state_d = ST_FETCH;
            else                      state_d = ST_WB;
         end
         ST_WB:   state_d = ST_FETCH;
         default: state_d = ST_TRAP;
      endcase
   end

   // Outputs are forced low while reset is held, so the datapath sees no strobes.
   always_comb begin
      PCWrite  = 1'b0;
      PCSrc    = PCSRC_SEQ;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = REGDST_RT;
      MemtoReg = M2R_ALU;
      ALUSrc   = 1'b0;
      ALUCtrl  = ALU_NONE;
      ExtOp    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
         end
         ST_DECODE: begin
            if (iclass == CL_JAL) begin
               PCWrite  = 1'b1;
               PCSrc    = PCSRC_JMP;
               RegWrite = 1'b1;
               RegDst   = REGDST_RA;
               MemtoReg = M2R_PC4;
               retire   = 1'b1;
            end else if (iclass == CL_JR) begin
               PCWrite = 1'b1;
               PCSrc   = PCSRC_RS;
               retire  = 1'b1;
            end
         end
         ST_EXEC: begin
            case (iclass)
               CL_ADDU, CL_SUBU, CL_SLL: ALUCtrl = rtype_alu(iclass);
               CL_ORI: begin
                  ALUCtrl = ALU_OR;
                  ALUSrc  = 1'b1;
                  ExtOp   = 1'b1;
               end
               CL_LW, CL_SW: begin
                  ALUCtrl = ALU_ADD;
                  ALUSrc  = 1'b1;
               end
               CL_BEQ, CL_BLEZ: begin
                  ALUCtrl = ALU_SUB;
                  PCSrc   = PCSRC_BR;
                  PCWrite = (iclass == CL_BEQ) ? zero : lez;
                  retire  = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (iclass == CL_SW);
            ALUCtrl  = ALU_ADD;
            ALUSrc   = 1'b1;
            // A store finishes in its ack cycle; gating on ack keeps stalled cycles retire-free.
            retire   = (iclass == CL_SW) && dmem_ack;
         end
         ST_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            case (iclass)
               CL_ADDU, CL_SUBU, CL_SLL: begin
                  RegDst  = REGDST_RD;
                  ALUCtrl = rtype_alu(iclass);
               end
               CL_ORI: begin
                  ALUCtrl = ALU_OR;
                  ALUSrc  = 1'b1;
                  ExtOp   = 1'b1;
               end
               CL_LUI:  MemtoReg = M2R_LUI;
               CL_LW:   MemtoReg = M2R_MEM;
               default: ;
            endcase
         end
         ST_TRAP: illegal = 1'b1;
         default: ;
      endcase
      if (!reset_n) begin
         PCWrite  = 1'b0;
         PCSrc    = 2'b00;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         RegDst   = 2'b00;
         MemtoReg = 2'b00;
         ALUSrc   = 1'b0;
         ALUCtrl  = 3'b000;
         ExtOp    = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         retire   = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each instruction is walked cycle by cycle
// against a hand-built table of the full output vector.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op, func;
   logic       zero, lez, dmem_ack;
   logic       PCWrite, IRWrite, RegWrite, ALUSrc, ExtOp;
   logic       dmem_req, dmem_we, retire, illegal;
   logic [1:0] PCSrc, RegDst, MemtoReg;
   logic [2:0] ALUCtrl, state;
   logic [20:0] obs;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op       (op),
      .func     (func),
      .zero     (zero),
      .lez      (lez),
      .dmem_ack (dmem_ack),
      .PCWrite  (PCWrite),
      .PCSrc    (PCSrc),
      .IRWrite  (IRWrite),
      .RegWrite (RegWrite),
      .RegDst   (RegDst),
      .MemtoReg (MemtoReg),
      .ALUSrc   (ALUSrc),
      .ALUCtrl  (ALUCtrl),
      .ExtOp    (ExtOp),
      .dmem_req (dmem_req),
      .dmem_we  (dmem_we),
      .retire   (retire),
      .illegal  (illegal),
      .state    (state)
   );

   assign obs = {state, PCWrite, PCSrc, IRWrite, RegWrite, RegDst, MemtoReg,
                 ALUSrc, ALUCtrl, ExtOp, dmem_req, dmem_we, retire, illegal};

   // Builds an expected output vector in the same field order as obs.
   function automatic logic [20:0] ev(input logic [2:0] st, input logic pcw,
                                      input logic [1:0] pcs, input logic irw,
                                      input logic rw, input logic [1:0] rd,
                                      input logic [1:0] m2r, input logic asrc,
                                      input logic [2:0] alu, input logic ext,
                                      input logic req, input logic we,
                                      input logic ret, input logic ill);
      return {st, pcw, pcs, irw, rw, rd, m2r, asrc, alu, ext, req, we, ret, ill};
   endfunction

   localparam logic [20:0] F_VEC = {3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00,
                                    1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [20:0] D_VEC = {3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00,
                                    1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_reset();
      reset_n = 1'b0; op = 6'b100011; func = 6'b0;
      zero = 1'b1; lez = 1'b1; dmem_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== 21'd0) begin
         fails++;
         $display("[TB] FAIL reset_hold: got %h expected %h", obs, 21'd0);
      end
      reset_n = 1'b1; zero = 1'b0; lez = 1'b0; dmem_ack = 1'b0;
      #1;
      checks++;
      if (obs !== F_VEC) begin
         fails++;
         $display("[TB] FAIL reset_release: got %h expected %h", obs, F_VEC);
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  fn[3]  = '{6'b100001, 6'b100011, 6'b000000};
      logic [2:0]  alu[3] = '{3'b010, 3'b011, 3'b100};
      logic [20:0] exp_v[$];
      for (int k = 0; k < 3; k++) begin
         exp_v = '{F_VEC, D_VEC,
                   ev(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, alu[k], 0, 0, 0, 0, 0),
                   ev(3'd4, 0, 2'b00, 0, 1, 2'b01, 2'b00, 0, alu[k], 0, 0, 0, 1, 0)};
         op = 6'b000000; func = fn[k]; dmem_ack = 1'b0;
         foreach (exp_v[i]) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
               fails++;
               $display("[TB] FAIL rtype func=%b cycle %0d: got %h expected %h", fn[k], i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_ori_lui();
      logic [20:0] exp_v[$];
      exp_v = '{F_VEC, D_VEC,
                ev(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b001, 1, 0, 0, 0, 0),
                ev(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b00, 1, 3'b001, 1, 0, 0, 1, 0),
                F_VEC, D_VEC,
                ev(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b01, 0, 3'b111, 0, 0, 0, 1, 0)};
      foreach (exp_v[i]) begin
         op = (i < 4) ? 6'b001101 : 6'b001111;
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL ori_lui cycle %0d: got %h expected %h", i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_stall();
      logic [20:0] mv = ev(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 1, 0, 0, 0);
      logic [20:0] exp_v[$];
      logic        ack_v[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_v = '{F_VEC, D_VEC,
                ev(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 0, 0, 0, 0),
                mv, mv, mv,
                ev(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b10, 0, 3'b111, 0, 0, 0, 1, 0)};
      op = 6'b100011; func = 6'b0;
      foreach (exp_v[i]) begin
         dmem_ack = ack_v[i];
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL lw_stall cycle %0d: got %h expected %h", i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_sw();
      logic [20:0] exp_v[$];
      exp_v = '{F_VEC, D_VEC,
                ev(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 0, 0, 0, 0),
                ev(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 1, 1, 1, 0)};
      op = 6'b101011;
      foreach (exp_v[i]) begin
         dmem_ack = (i == 3);
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL sw cycle %0d: got %h expected %h", i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_branches();
      logic [5:0]  bop[4]  = '{6'b000100, 6'b000100, 6'b000110, 6'b000110};
      logic        flag[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [20:0] exp_v[$];
      for (int k = 0; k < 4; k++) begin
         exp_v = '{F_VEC, D_VEC,
                   ev(3'd2, flag[k], 2'b01, 0, 0, 2'b00, 2'b00, 0, 3'b011, 0, 0, 0, 1, 0)};
         op = bop[k];
         // The unrelated flag is driven opposite so a swapped select shows up.
         zero = (k < 2) ? flag[k] : ~flag[k];
         lez  = (k < 2) ? ~flag[k] : flag[k];
         foreach (exp_v[i]) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
               fails++;
               $display("[TB] FAIL branch op=%b flag=%b cycle %0d: got %h expected %h", bop[k], flag[k], i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
         end
      end
      zero = 1'b0; lez = 1'b0;
   endtask

   task automatic test_jal_jr();
      logic [20:0] exp_v[$];
      exp_v = '{F_VEC,
                ev(3'd1, 1, 2'b10, 0, 1, 2'b10, 2'b11, 0, 3'b111, 0, 0, 0, 1, 0),
                F_VEC,
                ev(3'd1, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 3'b111, 0, 0, 0, 1, 0)};
      foreach (exp_v[i]) begin
         op   = (i < 2) ? 6'b000011 : 6'b000000;
         func = (i < 2) ? 6'b000000 : 6'b001000;
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL jal_jr cycle %0d: got %h expected %h", i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_trap(input logic [5:0] top, input logic [5:0] tfn, input int hold);
      logic [20:0] tv = ev(3'd7, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 3'b111, 0, 0, 0, 0, 1);
      logic [20:0] exp_v[$];
      exp_v = '{F_VEC, D_VEC};
      for (int k = 0; k < hold; k++) exp_v.push_back(tv);
      op = top; func = tfn;
      foreach (exp_v[i]) begin
         dmem_ack = i[0];
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL trap op=%b func=%b cycle %0d: got %h expected %h", top, tfn, i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 21'd0) begin
         fails++;
         $display("[TB] FAIL trap_reset: got %h expected %h", obs, 21'd0);
      end
      @(posedge clk); #1;
      op = 6'b0; func = 6'b100001;
      reset_n = 1'b1;
      #1;
      checks++;
      if (obs !== F_VEC) begin
         fails++;
         $display("[TB] FAIL trap_release: got %h expected %h", obs, F_VEC);
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [20:0] mv = ev(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 1, 1, 0, 0);
      logic [20:0] exp_v[$];
      exp_v = '{F_VEC, D_VEC,
                ev(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 3'b010, 0, 0, 0, 0, 0), mv};
      op = 6'b101011; dmem_ack = 1'b0;
      foreach (exp_v[i]) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_v[i]) begin
            fails++;
            $display("[TB] FAIL sw_abort cycle %0d: got %h expected %h", i, obs, exp_v[i]);
         end
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || retire !== 1'b0 || obs !== 21'd0) begin
         fails++;
         $display("[TB] FAIL sw_abort_reset: got req=%b retire=%b vec=%h expected req=0 retire=0 vec=0", dmem_req, retire, obs);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || IRWrite !== 1'b1 || obs !== F_VEC) begin
         fails++;
         $display("[TB] FAIL sw_abort_release: got state=%0d irw=%b vec=%h expected state=0 irw=1 vec=%h", state, IRWrite, obs, F_VEC);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_ori_lui();
      test_lw_stall();
      test_sw();
      test_branches();
      test_jal_jr();
      test_trap(6'b111111, 6'b000000, 20);
      test_trap(6'b000000, 6'b101010, 20);
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
